// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-codes, FSM states, flag indices.
package alu_pkg;

    // Arithmetic group (l = 0)
    localparam logic [2:0] OP_NEGA = 3'b000;
    localparam logic [2:0] OP_NEGB = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_ADDC = 3'b100;
    localparam logic [2:0] OP_SUBC = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

    // Logic group (l = 1)
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    // Control FSM: DONE is the single cycle that presents a finished multiply
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the packed flag register
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_S    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one iteration per clock after load.
// The product port shows the value after the current iteration, so on the
// cycle where last=1 it already carries the complete A*B.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    logic [SW-1:0]      step_q, step_d;
    logic               run_q, run_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     partial;

    // Upper half accumulates the multiplicand when the current multiplier bit is set, then the pair shifts right
    always_comb begin
        step_d  = step_q;
        run_d   = run_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        last    = run_q && (step_q == LAST_STEP);
        if (load) begin
            step_d  = '0;
            run_d   = 1'b1;
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
        end else if (run_q) begin
            acc_d  = {partial, acc_q[WIDTH-1:1]};
            step_d = step_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    assign product = acc_d;

    // Multiplier state registers; reset abandons any iteration in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= '0;
            run_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            step_q  <= step_d;
            run_q   <= run_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with registered result, persistent Z/C/S/V flags,
// start/done handshake and a multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             l,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             v,
    output logic             busy,
    output logic             done
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic                 done_q, done_d;

    logic                 mul_load;
    logic                 mul_last;
    logic [2*WIDTH-1:0]   mul_product;
    logic                 is_mul_op;

    logic [WIDTH-1:0]     add_x, add_y;
    logic                 add_cin;
    logic [WIDTH:0]       sum;
    logic                 add_v;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v, alu_wr_r;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .last    (mul_last)
    );

    // Every arithmetic op maps onto one WIDTH+1 bit adder: x + y + cin
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            OP_NEGA: begin
                add_x   = ~a;
                add_y   = '0;
                add_cin = 1'b1;
            end
            OP_NEGB: begin
                add_x   = ~b;
                add_y   = '0;
                add_cin = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                add_y   = ~b;
                add_cin = 1'b1;
            end
            OP_ADDC: begin
                add_cin = flags_q[FLAG_C];
            end
            OP_SUBC: begin
                add_y   = ~b;
                add_cin = flags_q[FLAG_C];
            end
            default: begin
            end
        endcase
        sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
    end

    // Result, carry and overflow for all single-cycle ops; CMP leaves r untouched
    always_comb begin
        alu_res  = sum[WIDTH-1:0];
        alu_c    = sum[WIDTH];
        alu_v    = add_v;
        alu_wr_r = 1'b1;
        if (l) begin
            alu_c = 1'b0;
            alu_v = 1'b0;
            case (op)
                OP_AND: alu_res = a & b;
                OP_OR:  alu_res = a | b;
                OP_XOR: alu_res = a ^ b;
                OP_NOT: alu_res = ~a;
                OP_SHL: begin
                    alu_res = {a[WIDTH-2:0], 1'b0};
                    alu_c   = a[WIDTH-1];
                end
                OP_SHR: begin
                    alu_res = {1'b0, a[WIDTH-1:1]};
                    alu_c   = a[0];
                end
                OP_ROL: begin
                    alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
                    alu_c   = a[WIDTH-1];
                end
                OP_ROR: begin
                    alu_res = {a[0], a[WIDTH-1:1]};
                    alu_c   = a[0];
                end
                default: alu_res = '0;
            endcase
        end else if (op == OP_CMP) begin
            alu_wr_r = 1'b0;
        end
    end

    // Next-state and register-update logic; DONE accepts new work exactly like IDLE
    always_comb begin
        is_mul_op = !l && (op == OP_MUL);
        state_d   = state_q;
        r_d       = r_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        mul_load  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (is_mul_op) begin
                        mul_load = 1'b1;
                        state_d  = MUL;
                    end else begin
                        if (alu_wr_r) begin
                            r_d = alu_res;
                        end
                        flags_d[FLAG_Z] = (alu_res == '0);
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_S] = alu_res[WIDTH-1];
                        flags_d[FLAG_V] = alu_v;
                        done_d          = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    r_d             = mul_product[WIDTH-1:0];
                    flags_d[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
                    flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_S] = mul_product[WIDTH-1];
                    flags_d[FLAG_V] = 1'b0;
                    done_d          = 1'b1;
                    state_d         = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Architectural registers; reset wins over any pending start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign r    = r_q;
    assign z    = flags_q[FLAG_Z];
    assign c    = flags_q[FLAG_C];
    assign s    = flags_q[FLAG_S];
    assign v    = flags_q[FLAG_V];
    assign busy = (state_q == MUL);
    assign done = done_q;

endmodule
